// File: rtl/div_arbiter_pkg.sv
// Shared types and constants for the round-robin divider arbiter.
package div_arbiter_pkg;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam int DIV_LATENCY = 20;
  localparam int WDOG_LIMIT  = 32;
endpackage

// File: rtl/serial_div20.sv
// Shared unsigned restoring serial divider; one quotient bit per cycle, no reset.
module serial_div20
  import div_arbiter_pkg::*;
#(
  parameter int W = DIV_LATENCY
) (
  input  logic         clk,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);
  localparam int CW = $clog2(W);

  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [W-1:0]  dvs;
  logic [CW-1:0] cnt;

  function automatic logic [2*W-1:0] step(input logic [W-1:0] r, input logic [W-1:0] q,
                                          input logic [W-1:0] d);
    logic [W:0] sh;
    logic [W:0] diff;
    sh   = {r, q[W-1]};
    diff = sh - {1'b0, d};
    if (!diff[W]) return {diff[W-1:0], q[W-2:0], 1'b1};
    else          return {sh[W-1:0], q[W-2:0], 1'b0};
  endfunction

  // The first step is folded into the start cycle, so ready is low for the
  // start cycle plus W-1 further cycles.
  always_ff @(posedge clk) begin
    if (start) begin
      {rem, quo} <= step('0, dividend, divisor);
      dvs        <= divisor;
      cnt        <= CW'(W - 1);
    end else if (cnt != '0) begin
      {rem, quo} <= step(rem, quo, dvs);
      cnt        <= cnt - 1'b1;
    end
  end

  assign ready     = (cnt == '0) && !start;
  assign quotient  = quo;
  assign remainder = rem;
endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter time-sharing one serial divider among NREQ requesters.
// Handshakes: a transfer happens on a cycle where valid & ready are both high; valid holds data stable until then.
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter  int N    = 20,
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_divident,
  input  logic [NREQ*N-1:0] req_divider,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic [N-1:0]      rsp_quotient,
  output logic [N-1:0]      rsp_reminder,
  output logic              rsp_div0,
  output logic              busy,
  output state_t            dbg_state
);
  state_t        state;
  logic [IW-1:0] ptr;
  logic [N-1:0]  lat_dvd;
  logic [N-1:0]  lat_dvs;
  logic [5:0]    wait_cnt;
  logic          gnt_any;
  logic [IW-1:0] gnt_idx;
  logic [N-1:0]  sel_dvd;
  logic [N-1:0]  sel_dvs;
  logic          div_start;
  logic          div_ready;
  logic [N-1:0]  div_q;
  logic [N-1:0]  div_r;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign sel_dvd   = req_divident[int'(gnt_idx)*N +: N];
  assign sel_dvs   = req_divider[int'(gnt_idx)*N +: N];
  assign req_ready = (rst_n && state == S_IDLE && gnt_any) ? (NREQ'(1) << gnt_idx) : '0;
  assign busy      = (state != S_IDLE);
  assign div_start = (state == S_LAUNCH);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ptr          <= '0;
      lat_dvd      <= '0;
      lat_dvs      <= '0;
      wait_cnt     <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_quotient <= '0;
      rsp_reminder <= '0;
      rsp_div0     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            lat_dvd <= sel_dvd;
            lat_dvs <= sel_dvs;
            rsp_id  <= gnt_idx;
            ptr     <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            if (sel_dvs == '0) begin
              rsp_quotient <= '1;
              rsp_reminder <= sel_dvd;
              rsp_div0     <= 1'b1;
              rsp_valid    <= 1'b1;
              state        <= S_RESP;
            end else begin
              state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // The divider has no reset, so its ready is meaningless until after the first WAIT cycle.
          if (wait_cnt != '0 && div_ready) begin
            rsp_quotient <= div_q;
            rsp_reminder <= div_r;
            rsp_div0     <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= S_RESP;
          end else if (wait_cnt == 6'(WDOG_LIMIT - 1)) begin
            rsp_quotient <= '1;
            rsp_reminder <= lat_dvd;
            rsp_div0     <= 1'b1;
            rsp_valid    <= 1'b1;
            state        <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  serial_div20 #(.W(N)) u_div (
    .clk       (clk),
    .start     (div_start),
    .dividend  (lat_dvd),
    .divisor   (lat_dvs),
    .ready     (div_ready),
    .quotient  (div_q),
    .remainder (div_r)
  );
endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter: arbitration order, latency, div-by-zero, backpressure, reset.
module tb_div_arbiter;
  import div_arbiter_pkg::*;

  localparam int N    = 20;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*N-1:0] req_divident = '0;
  logic [NREQ*N-1:0] req_divider = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [1:0]        rsp_id;
  logic [N-1:0]      rsp_quotient;
  logic [N-1:0]      rsp_reminder;
  logic              rsp_div0;
  logic              busy;
  state_t            dbg_state;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int start_cnt = 0;
  logic [1:0] exp_q[$];

  div_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_divident (req_divident),
    .req_divider  (req_divider),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_quotient (rsp_quotient),
    .rsp_reminder (rsp_reminder),
    .rsp_div0     (rsp_div0),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut.div_start) start_cnt <= start_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [N-1:0] dvd, input logic [N-1:0] dvs);
    req_divident[id*N +: N] = dvd;
    req_divider[id*N +: N]  = dvs;
    req_valid[id]           = 1'b1;
    #1;
  endtask

  task automatic wait_accept(output int acc, output int g);
    bit found = 1'b0;
    acc = -1;
    g   = -1;
    for (int i = 0; i < 100 && !found; i++) begin
      if ((req_valid & req_ready) != '0) begin
        found = 1'b1;
        acc   = cyc;
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
      end else begin
        tick();
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL accept_timeout no req_ready within 100 cycles");
    end
  endtask

  task automatic wait_rsp(output int c);
    bit found = 1'b0;
    c = -1;
    for (int i = 0; i < 80 && !found; i++) begin
      if (rsp_valid) begin
        found = 1'b1;
        c     = cyc;
      end else begin
        tick();
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rsp_timeout no rsp_valid within 80 cycles");
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    req_valid = '1;
    tick();
    tick();
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_req_ready got %b exp 0000", req_ready);
    end
    checks++;
    if ({rsp_valid, busy, rsp_div0} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 000", {rsp_valid, busy, rsp_div0});
    end
    checks++;
    if (rsp_quotient !== '0 || rsp_reminder !== '0 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_data got q=%0d r=%0d id=%0d exp 0 0 0", rsp_quotient, rsp_reminder, rsp_id);
    end
    req_valid = '0;
    rst_n     = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] tq[4];
    logic [N-1:0] tr[4];
    logic [1:0]   e;
    int acc, g, r;
    tq = '{20'hFFFFF, 20'd110, 20'd60, 20'd43};
    tr = '{20'd100, 20'd0, 20'd0, 20'd1};
    for (int i = 0; i < NREQ; i++) begin
      req_divident[i*N +: N] = N'(100 + 10 * i);
      req_divider[i*N +: N]  = N'(i);
    end
    exp_q     = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rsp_ready = 1'b1;
    req_valid = '1;
    #1;
    for (int n = 0; n < 5; n++) begin
      wait_accept(acc, g);
      e = exp_q.pop_front();
      checks++;
      if (g !== int'(e)) begin
        errors++;
        $display("FAIL rr_grant[%0d] got %0d exp %0d", n, g, e);
      end
      wait_rsp(r);
      checks++;
      if (rsp_id !== e || rsp_quotient !== tq[e] || rsp_reminder !== tr[e]) begin
        errors++;
        $display("FAIL rr_rsp[%0d] got id=%0d q=%0d r=%0d exp id=%0d q=%0d r=%0d",
                 n, rsp_id, rsp_quotient, rsp_reminder, e, tq[e], tr[e]);
      end
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL rr_ready_in_resp got %b exp 0000", req_ready);
      end
      if (n == 4) req_valid = '0;
      tick();
    end
    rsp_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle_busy got %b exp 0", busy);
    end
  endtask

  task automatic test_single();
    int acc, g, r;
    set_req(2, 20'd100000, 20'd7);
    wait_accept(acc, g);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant got %b exp 0100", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy got %b exp 1", busy);
    end
    wait_rsp(r);
    checks++;
    if (r - acc != 22) begin
      errors++;
      $display("FAIL single_latency got %0d exp 22", r - acc);
    end
    checks++;
    if (rsp_id !== 2'd2 || rsp_quotient !== 20'd14285 || rsp_reminder !== 20'd5 || rsp_div0 !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp got id=%0d q=%0d r=%0d d0=%b exp id=2 q=14285 r=5 d0=0",
               rsp_id, rsp_quotient, rsp_reminder, rsp_div0);
    end
    consume();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after got valid=%b busy=%b exp 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_div0();
    int acc, g, r, s;
    s = start_cnt;
    set_req(1, 20'd1234, 20'd0);
    wait_accept(acc, g);
    tick();
    req_valid = '0;
    wait_rsp(r);
    checks++;
    if (r - acc != 1) begin
      errors++;
      $display("FAIL div0_latency got %0d exp 1", r - acc);
    end
    checks++;
    if (rsp_div0 !== 1'b1 || rsp_quotient !== 20'hFFFFF || rsp_reminder !== 20'd1234 || rsp_id !== 2'd1) begin
      errors++;
      $display("FAIL div0_rsp got d0=%b q=%h r=%0d id=%0d exp d0=1 q=fffff r=1234 id=1",
               rsp_div0, rsp_quotient, rsp_reminder, rsp_id);
    end
    consume();
    checks++;
    if (start_cnt != s) begin
      errors++;
      $display("FAIL div0_start got %0d pulses exp 0", start_cnt - s);
    end
  endtask

  task automatic test_backpressure();
    int acc, g, r;
    logic [N-1:0] sq, sr;
    set_req(3, 20'd50, 20'd6);
    wait_accept(acc, g);
    tick();
    req_valid = '0;
    wait_rsp(r);
    sq = rsp_quotient;
    sr = rsp_reminder;
    checks++;
    if (sq !== 20'd8 || sr !== 20'd2 || rsp_id !== 2'd3) begin
      errors++;
      $display("FAIL bp_rsp got q=%0d r=%0d id=%0d exp q=8 r=2 id=3", sq, sr, rsp_id);
    end
    set_req(0, 20'd9, 20'd3);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_quotient !== 20'd8 || rsp_reminder !== 20'd2 ||
          rsp_id !== 2'd3 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b q=%0d r=%0d id=%0d rdy=%b exp v=1 q=8 r=2 id=3 rdy=0000",
                 i, rsp_valid, rsp_quotient, rsp_reminder, rsp_id, req_ready);
      end
      tick();
    end
    consume();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=0001", rsp_valid, req_ready);
    end
    wait_accept(acc, g);
    tick();
    req_valid = '0;
    wait_rsp(r);
    checks++;
    if (rsp_id !== 2'd0 || rsp_quotient !== 20'd3 || rsp_reminder !== 20'd0) begin
      errors++;
      $display("FAIL bp_next got id=%0d q=%0d r=%0d exp id=0 q=3 r=0", rsp_id, rsp_quotient, rsp_reminder);
    end
    consume();
  endtask

  task automatic test_reset_in_wait();
    int acc, g, r;
    bit stale;
    set_req(0, 20'd777, 20'd5);
    wait_accept(acc, g);
    tick();
    req_valid = '0;
    repeat (5) tick();
    checks++;
    if (dbg_state !== S_WAIT) begin
      errors++;
      $display("FAIL rst_pre_state got %0d exp %0d", dbg_state, S_WAIT);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_div0 !== 1'b0 || req_ready !== 4'b0000 ||
        rsp_quotient !== '0 || rsp_reminder !== '0 || rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL rst_outputs got v=%b busy=%b d0=%b rdy=%b q=%0d r=%0d id=%0d exp all 0",
               rsp_valid, busy, rsp_div0, req_ready, rsp_quotient, rsp_reminder, rsp_id);
    end
    tick();
    tick();
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale) begin
      errors++;
      $display("FAIL rst_stale got stale response after reset exp none");
    end
    set_req(1, 20'd1048575, 20'd1);
    wait_accept(acc, g);
    tick();
    req_valid = '0;
    wait_rsp(r);
    checks++;
    if (r - acc != 22 || rsp_id !== 2'd1 || rsp_quotient !== 20'd1048575 || rsp_reminder !== 20'd0) begin
      errors++;
      $display("FAIL rst_next got lat=%0d id=%0d q=%0d r=%0d exp lat=22 id=1 q=1048575 r=0",
               r - acc, rsp_id, rsp_quotient, rsp_reminder);
    end
    consume();
  endtask

  task automatic test_boundary();
    int acc, g, r;
    set_req(2, 20'd3, 20'd1048575);
    wait_accept(acc, g);
    tick();
    req_valid = '0;
    wait_rsp(r);
    checks++;
    if (r - acc != 22 || rsp_quotient !== 20'd0 || rsp_reminder !== 20'd3 || rsp_div0 !== 1'b0) begin
      errors++;
      $display("FAIL boundary_small got lat=%0d q=%0d r=%0d d0=%b exp lat=22 q=0 r=3 d0=0",
               r - acc, rsp_quotient, rsp_reminder, rsp_div0);
    end
    consume();
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_div0();
    test_backpressure();
    test_reset_in_wait();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
